// File: rtl/s10077_pkg.sv
// Shared defaults and state type for the S10077 line-capture path.
package s10077_pkg;
  localparam int unsigned NPIX  = 1024;
  localparam int unsigned DW    = 12;
  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    READOUT
  } cap_state_t;
endpackage

// File: rtl/line_buf.sv
// Simple dual-port line RAM: one write port, one synchronous read port with enable.
module line_buf #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned DW    = 12,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [DEPTH];

  // Read data holds when i_re is low, so it doubles as a stall register.
  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/line_capture.sv
// Captures ADC samples on TRIG rising edges into a line buffer, closes the line on
// EOC_EDGE and streams it out over valid/ready with line/drop/overflow status.
module line_capture #(
  parameter int unsigned NPIX  = s10077_pkg::NPIX,
  parameter int unsigned DW    = s10077_pkg::DW,
  parameter int unsigned CNT_W = s10077_pkg::CNT_W
) (
  input  logic                     FPGA_CLK,
  input  logic                     FPGA_RST,
  input  logic                     TRIG,
  input  logic                     EOC_EDGE,
  input  logic [DW-1:0]            ADC_DATA,
  output logic [DW-1:0]            PIX_DATA,
  output logic [$clog2(NPIX)-1:0]  PIX_IDX,
  output logic                     PIX_VALID,
  input  logic                     PIX_READY,
  output logic                     PIX_LAST,
  output logic                     LINE_BUSY,
  output logic                     LINE_OVF,
  output logic [CNT_W-1:0]         LINE_COUNT,
  output logic [CNT_W-1:0]         DROP_COUNT
);
  import s10077_pkg::*;

  localparam int unsigned AW   = $clog2(NPIX);
  localparam logic [AW:0] FULL = (AW+1)'(NPIX);

  cap_state_t r_state, w_state_nxt;

  logic          r_trig_s1, r_trig_s2, r_trig_s3, r_trig_p;
  logic [DW-1:0] r_adc_s1, r_adc_s2, r_adc_p;

  logic [AW:0]   r_ptr, r_len, r_rd_idx;
  logic [AW:0]   w_ptr_adv;
  logic          w_full, w_wr_en;
  logic [AW-1:0] w_waddr;

  logic          r_s1_valid;
  logic [AW-1:0] r_s1_idx;
  logic [DW-1:0] w_rd_data;
  logic          w_rd_en, w_s1_free, w_out_ready, w_out_accept;

  logic          r_out_valid, r_out_last, r_busy, r_ovf;
  logic [DW-1:0] r_out_data;
  logic [AW-1:0] r_out_idx;
  logic [CNT_W-1:0] r_line_cnt, r_drop_cnt;

  // ADC pipeline matches synchronizer depth so r_adc_p lines up with r_trig_p.
  always_ff @(posedge FPGA_CLK or negedge FPGA_RST) begin
    if (!FPGA_RST) begin
      r_trig_s1 <= 1'b0;
      r_trig_s2 <= 1'b0;
      r_trig_s3 <= 1'b0;
      r_trig_p  <= 1'b0;
      r_adc_s1  <= '0;
      r_adc_s2  <= '0;
      r_adc_p   <= '0;
    end else begin
      r_trig_s1 <= TRIG;
      r_trig_s2 <= r_trig_s1;
      r_trig_s3 <= r_trig_s2;
      r_trig_p  <= r_trig_s2 & ~r_trig_s3;
      r_adc_s1  <= ADC_DATA;
      r_adc_s2  <= r_adc_s1;
      r_adc_p   <= r_adc_s2;
    end
  end

  assign w_full       = (r_ptr == FULL);
  assign w_wr_en      = r_trig_p && ((r_state == IDLE) || ((r_state == CAPTURE) && !w_full));
  assign w_waddr      = (r_state == CAPTURE) ? r_ptr[AW-1:0] : '0;
  assign w_ptr_adv    = r_ptr + {{AW{1'b0}}, (r_trig_p && !w_full)};
  assign w_out_ready  = !r_out_valid || PIX_READY;
  assign w_out_accept = r_out_valid && PIX_READY;
  assign w_s1_free    = !r_s1_valid || w_out_ready;
  assign w_rd_en      = (r_state == READOUT) && (r_rd_idx < r_len) && w_s1_free;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (r_trig_p) w_state_nxt = CAPTURE;
      CAPTURE: if (EOC_EDGE) w_state_nxt = READOUT;
      READOUT: if (w_out_accept && r_out_last) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge FPGA_CLK or negedge FPGA_RST) begin
    if (!FPGA_RST) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != IDLE);
    end
  end

  // A trigger coinciding with EOC_EDGE is stored first and included in the length.
  always_ff @(posedge FPGA_CLK or negedge FPGA_RST) begin
    if (!FPGA_RST) begin
      r_ptr <= '0;
      r_len <= '0;
      r_ovf <= 1'b0;
    end else begin
      if ((r_state == IDLE) && r_trig_p) begin
        r_ptr <= (AW+1)'(1);
        r_ovf <= 1'b0;
      end
      if (r_state == CAPTURE) begin
        r_ptr <= w_ptr_adv;
        if (r_trig_p && w_full) r_ovf <= 1'b1;
        if (EOC_EDGE) r_len <= w_ptr_adv;
      end
    end
  end

  // RAM output register is stage 1, PIX_* registers are stage 2; both stall on !READY.
  always_ff @(posedge FPGA_CLK or negedge FPGA_RST) begin
    if (!FPGA_RST) begin
      r_rd_idx    <= '0;
      r_s1_valid  <= 1'b0;
      r_s1_idx    <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_idx   <= '0;
      r_out_last  <= 1'b0;
    end else if (r_state != READOUT) begin
      r_rd_idx    <= '0;
      r_s1_valid  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_rd_en) r_rd_idx <= r_rd_idx + (AW+1)'(1);
      if (w_s1_free) begin
        r_s1_valid <= w_rd_en;
        r_s1_idx   <= r_rd_idx[AW-1:0];
      end
      if (w_out_ready) begin
        r_out_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_out_data <= w_rd_data;
          r_out_idx  <= r_s1_idx;
          r_out_last <= ({1'b0, r_s1_idx} == (r_len - (AW+1)'(1)));
        end
      end
    end
  end

  always_ff @(posedge FPGA_CLK or negedge FPGA_RST) begin
    if (!FPGA_RST) begin
      r_line_cnt <= '0;
      r_drop_cnt <= '0;
    end else if (r_state == READOUT) begin
      if (EOC_EDGE && (r_drop_cnt != '1)) r_drop_cnt <= r_drop_cnt + 1'b1;
      if (w_out_accept && r_out_last) r_line_cnt <= r_line_cnt + 1'b1;
    end
  end

  line_buf #(
    .DEPTH (NPIX),
    .DW    (DW)
  ) u_line_buf (
    .i_clk   (FPGA_CLK),
    .i_we    (w_wr_en),
    .i_waddr (w_waddr),
    .i_wdata (r_adc_p),
    .i_re    (w_rd_en),
    .i_raddr (r_rd_idx[AW-1:0]),
    .o_rdata (w_rd_data)
  );

  assign PIX_DATA   = r_out_data;
  assign PIX_IDX    = r_out_idx;
  assign PIX_VALID  = r_out_valid;
  assign PIX_LAST   = r_out_last;
  assign LINE_BUSY  = r_busy;
  assign LINE_OVF   = r_ovf;
  assign LINE_COUNT = r_line_cnt;
  assign DROP_COUNT = r_drop_cnt;

endmodule

// File: tb/tb_line_capture.sv
// Directed and randomized checks of line_capture against a queue-based line model.
module tb_line_capture;
  import s10077_pkg::*;

  localparam int unsigned AW = $clog2(NPIX);

  logic              clk = 1'b0;
  logic              rst_n, trig, eoc, ready;
  logic [DW-1:0]     adc;
  logic [DW-1:0]     pix_data;
  logic [AW-1:0]     pix_idx;
  logic              pix_valid, pix_last, line_busy, line_ovf;
  logic [CNT_W-1:0]  line_count, drop_count;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: the current line is a queue of samples; counters are plain ints.
  logic [DW-1:0] line_q[$];
  bit            capturing = 0;
  bit            exp_ovf   = 0;
  int            exp_lines = 0;
  int            exp_drops = 0;

  always #5 clk = ~clk;

  line_capture dut (
    .FPGA_CLK   (clk),
    .FPGA_RST   (rst_n),
    .TRIG       (trig),
    .EOC_EDGE   (eoc),
    .ADC_DATA   (adc),
    .PIX_DATA   (pix_data),
    .PIX_IDX    (pix_idx),
    .PIX_VALID  (pix_valid),
    .PIX_READY  (ready),
    .PIX_LAST   (pix_last),
    .LINE_BUSY  (line_busy),
    .LINE_OVF   (line_ovf),
    .LINE_COUNT (line_count),
    .DROP_COUNT (drop_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_trig(input logic [DW-1:0] v);
    if (!capturing) begin
      line_q.delete();
      exp_ovf   = 0;
      capturing = 1;
    end
    if (line_q.size() < NPIX) line_q.push_back(v);
    else exp_ovf = 1;
  endtask

  task automatic pulse(input logic [DW-1:0] v);
    @(negedge clk);
    adc  = v;
    trig = 1'b1;
    repeat (3) @(negedge clk);
    trig = 1'b0;
    repeat (3) @(negedge clk);
    model_trig(v);
  endtask

  task automatic close_line();
    @(negedge clk);
    eoc = 1'b1;
    @(negedge clk);
    eoc = 1'b0;
    capturing = 0;
  endtask

  // Trigger whose internal edge lands in the same cycle as EOC_EDGE.
  task automatic pulse_with_eoc(input logic [DW-1:0] v);
    @(negedge clk);
    adc  = v;
    trig = 1'b1;
    repeat (3) @(negedge clk);
    eoc  = 1'b1;
    trig = 1'b0;
    @(negedge clk);
    eoc  = 1'b0;
    model_trig(v);
    capturing = 0;
  endtask

  task automatic reset_check(input string tag);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check({tag, "_valid"}, pix_valid, 0);
    check({tag, "_data"}, pix_data, 0);
    check({tag, "_idx"}, pix_idx, 0);
    check({tag, "_last"}, pix_last, 0);
    check({tag, "_busy"}, line_busy, 0);
    check({tag, "_ovf"}, line_ovf, 0);
    check({tag, "_lines"}, line_count, 0);
    check({tag, "_drops"}, drop_count, 0);
    capturing = 0;
    exp_ovf   = 0;
    exp_lines = 0;
    exp_drops = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // mode: 0 READY=1, 1 READY toggles, 2 READY random. abort_at>0 resets at that cycle.
  task automatic drain(input string tag, input int mode, input int n_eoc,
                       input bit trig_in_ro, input int abort_at);
    int got = 0;
    int first_v = -1;
    bit done = 0;
    bit stall = 0;
    logic [DW-1:0] pd = '0;
    logic [AW-1:0] pi = '0;
    logic pl = 1'b0;
    for (int k = 1; k <= 4 * NPIX + 64 && !done; k++) begin
      @(negedge clk);
      eoc = ((n_eoc >= 1) && (k == 2)) || ((n_eoc >= 2) && (k == 4));
      if (trig_in_ro) begin
        if (k == 1) adc = DW'($urandom);
        trig = (k < 5);
      end
      if (k == abort_at) begin
        eoc  = 1'b0;
        trig = 1'b0;
        reset_check({tag, "_abort"});
        return;
      end
      case (mode)
        0: ready = 1'b1;
        1: ready = k[0];
        default: ready = 1'($urandom_range(0, 1));
      endcase
      if (stall) begin
        check({tag, "_stall_valid"}, pix_valid, 1);
        check({tag, "_stall_data"}, pix_data, pd);
        check({tag, "_stall_idx"}, pix_idx, pi);
        check({tag, "_stall_last"}, pix_last, pl);
      end
      if (pix_valid && first_v < 0) first_v = k;
      if (pix_valid && ready) begin
        if (got < line_q.size()) begin
          check({tag, "_data"}, pix_data, line_q[got]);
          check({tag, "_idx"}, pix_idx, got);
          check({tag, "_last"}, pix_last, (got == line_q.size() - 1));
        end else begin
          check({tag, "_overrun"}, got + 1, line_q.size());
        end
        got++;
        if (pix_last) done = 1;
      end
      stall = pix_valid && !ready;
      pd = pix_data;
      pi = pix_idx;
      pl = pix_last;
    end
    eoc  = 1'b0;
    trig = 1'b0;
    check({tag, "_len"}, got, line_q.size());
    check({tag, "_first_valid_cyc"}, first_v, 2);
    exp_lines = (exp_lines + 1) % (1 << CNT_W);
    exp_drops = exp_drops + n_eoc;
    @(negedge clk);
    check({tag, "_line_count"}, line_count, exp_lines);
    check({tag, "_drop_count"}, drop_count, exp_drops);
    check({tag, "_busy_end"}, line_busy, 0);
    check({tag, "_ovf"}, line_ovf, exp_ovf);
    check({tag, "_valid_end"}, pix_valid, 0);
  endtask

  initial begin
    rst_n = 1'b1;
    trig  = 1'b0;
    eoc   = 1'b0;
    ready = 1'b0;
    adc   = '0;
    reset_check("reset");
    repeat (2) @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      pulse(DW'(100 + i));
      if (i == 0) check("t1_busy_capture", line_busy, 1);
    end
    close_line();
    drain("t1", 0, 0, 0, 0);

    for (int i = 0; i < 8; i++) pulse(DW'(100 + i));
    close_line();
    drain("t2", 1, 0, 0, 0);

    for (int i = 0; i < NPIX + 3; i++) pulse(DW'($urandom));
    close_line();
    drain("t3", 0, 0, 0, 0);

    for (int i = 0; i < 8; i++) pulse(DW'($urandom));
    close_line();
    drain("t4", 0, 2, 1, 0);
    for (int i = 0; i < 6; i++) pulse(DW'($urandom));
    close_line();
    drain("t4_next", 2, 0, 0, 0);

    for (int i = 0; i < 4; i++) pulse(DW'($urandom));
    pulse_with_eoc(DW'($urandom));
    drain("t5", 0, 0, 0, 0);

    for (int i = 0; i < 3; i++) pulse(DW'($urandom));
    reset_check("t6_cap_rst");
    for (int i = 0; i < 4; i++) pulse(DW'($urandom));
    close_line();
    drain("t6_after_cap", 0, 0, 0, 0);

    for (int i = 0; i < 10; i++) pulse(DW'($urandom));
    close_line();
    drain("t6_ro", 0, 0, 0, 5);
    for (int i = 0; i < 3; i++) pulse(DW'($urandom));
    close_line();
    drain("t6_after_ro", 2, 0, 0, 0);

    for (int r = 0; r < 6; r++) begin
      int n;
      n = $urandom_range(1, 20);
      for (int i = 0; i < n; i++) pulse(DW'($urandom));
      close_line();
      drain("rand", 2, 0, 0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
